seq_alu_core: RTL and testbench
===============================

// Module: seq_alu_core
// PURPOSE
//  Parametrised, registered ALU built on the team's gate-level primitives. It generalises the
//  2/3-input gates and the 4-bit zero-detect NOR to WIDTH-bit operands.
//  Adds ADD/SUB with full flag generation and an unsigned shift-add multiplier that takes
//  multiple cycles. Sits between the register file and writeback.
//  Uses a start/busy/done handshake, and results and flags are held until the next completion.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal WIDTH >= 2. Counter width = clog2(WIDTH)+1.
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        request; sampled only when busy==0
//  op         in   4        opcode, sampled with start
//  a          in   WIDTH    operand A, sampled with start
//  b          in   WIDTH    operand B, sampled with start
//  busy       out  1        multiply in progress
//  done       out  1        one-cycle completion pulse
//  result     out  WIDTH    result (low half of product for MUL)
//  result_hi  out  WIDTH    high half of product for MUL; 0 for all other ops
//  zf,nf,cf,vf out 1 each   zero, negative, carry/borrow, signed-overflow flags
// BEHAVIOUR
//  Reset (async, any state, including mid-multiply):
//   - state=IDLE.
//   - busy, done, result, result_hi, zf, nf, cf, vf all 0.
//   - multiplier counter and partial product cleared.
//  Opcodes:
//   - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 ADD a+b, 8 SUB a-b, 9 MUL (unsigned).
//   - 10-15 reserved: complete in one cycle with result=0, result_hi=0, zf=1, other flags 0.
//  States:
//   - IDLE -> MULT on accepted start with op==9.
//   - MULT -> IDLE after WIDTH iterations.
//   - Every other op stays in IDLE.
//  Single-cycle ops: start accepted at edge k; result, flags and done=1 visible after edge k.
//   - done drops after edge k+1 unless another start is accepted at edge k+1.
//   - Back-to-back accepts hold done high with the new result on each edge.
//  MUL timing:
//   - Edge k latches a, b; busy=1 after edge k.
//   - One shift-add iteration per edge, k+1 .. k+WIDTH.
//   - At edge k+WIDTH: {result_hi,result}=a*b, done=1, busy=0.
//   - busy is high for exactly WIDTH cycles. A new start can be accepted in the done cycle.
//  start while busy==1: ignored. No state change, no done, and operands are not re-sampled.
//  Outputs hold their last values between done pulses. done is never asserted without a
//   result/flag update on the same edge.
//  Flags, registered with the result:
//   - zf = NOR of all result bits (MUL: all 2*WIDTH product bits).
//   - nf = result[WIDTH-1] (MUL: result_hi[WIDTH-1]).
//   - ADD: cf = carry-out; vf = signed overflow (a,b same sign, result sign differs).
//   - SUB: cf = borrow (a<b unsigned); vf = signed overflow (a,b differ in sign, result sign != a sign).
//   - MUL: cf = vf = (result_hi != 0).
//   - Logic ops and NOT: cf = vf = 0.
//  Widths: ADD/SUB computed at WIDTH+1 bits; the MUL accumulator is 2*WIDTH bits; nothing is
//   sign-extended.
// TESTING  (WIDTH=8 unless noted)
//  1 Assert rst 3 cycles into a MUL -> all outputs 0 immediately (async); busy stays 0.
//    After release: ADD 1+1 -> result 0x02, done 1 cycle after start.
//  2 ADD a=0x7F b=0x01 -> result 0x80, nf=1, vf=1, cf=0, zf=0.
//    ADD 0xFF+0x01 -> result 0x00, zf=1, cf=1, vf=0.
//  3 SUB 0x05-0x05 -> 0x00, zf=1, cf=0.
//    SUB 0x00-0x01 -> 0xFF, cf=1, nf=1, vf=0.
//    SUB 0x80-0x01 -> 0x7F, vf=1.
//  4 MUL 0xFF*0xFF -> busy high 8 cycles, then done.
//    result_hi=0xFE, result=0x01, cf=vf=1, nf=1.
//    MUL 0x03*0x00 -> product 0, zf=1.
//  5 During MUL busy, drive start with ADD 0x10+0x10 -> ignored; MUL result unaffected.
//    Then XOR/AND/OR on 3 consecutive cycles -> done high 3 cycles, each result correct.
//  6 Logic and reserved ops:
//    - NOR 0x00,0x00 -> 0xFF, nf=1.
//    - XNOR 0xA5,0xA5 -> 0xFF.
//    - NOT 0xFF -> 0x00, zf=1.
//    - op=15 -> result 0, zf=1, done pulse.
//    Repeat 2-4 at WIDTH=4 and WIDTH=16.

Source files
------------

// File: rtl/seq_alu_core_if.sv
// seq_alu_core_if: start/busy/done request bus with operands, result and flags
interface seq_alu_core_if #(parameter int WIDTH = 8);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zf;
    logic             nf;
    logic             cf;
    logic             vf;
    modport master (output start, op, a, b, input busy, done, result, result_hi, zf, nf, cf, vf);
    modport slave  (input start, op, a, b, output busy, done, result, result_hi, zf, nf, cf, vf);
endinterface

// File: rtl/seq_alu_core.sv
// seq_alu_core: registered ALU with flags and a WIDTH-cycle shift-add unsigned multiplier
module seq_alu_core #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    seq_alu_core_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic {IDLE, MULT} state_t;
    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     add_hi;
    logic               accept;
    logic               is_mul;
    logic               last;
    logic               alu_cf;
    logic               alu_vf;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // next state: only an accepted MUL leaves IDLE, and it returns after the final iteration
    always_comb begin
        state_nxt = state == IDLE ? (accept && is_mul ? MULT : IDLE) : (last ? IDLE : MULT);
    end
    // combinational outputs: handshake decode, one multiplier step and the single-cycle ALU
    always_comb begin
        accept   = bus.start && state == IDLE;
        is_mul   = bus.op == 4'd9;
        last     = state == MULT && cnt == CW'(WIDTH - 1);
        bus.busy = state == MULT;
        add_hi   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
        acc_step = {add_hi, acc[WIDTH-1:1]};
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        diff     = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res  = '0;
        alu_cf   = 1'b0;
        alu_vf   = 1'b0;
        case (bus.op)
            4'd0: alu_res = bus.a & bus.b;
            4'd1: alu_res = ~(bus.a & bus.b);
            4'd2: alu_res = bus.a | bus.b;
            4'd3: alu_res = ~(bus.a | bus.b);
            4'd4: alu_res = bus.a ^ bus.b;
            4'd5: alu_res = ~(bus.a ^ bus.b);
            4'd6: alu_res = ~bus.a;
            4'd7: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = sum[WIDTH];
                alu_vf  = bus.a[WIDTH-1] == bus.b[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1];
            end
            4'd8: begin
                alu_res = diff[WIDTH-1:0];
                alu_cf  = diff[WIDTH];
                alu_vf  = bus.a[WIDTH-1] != bus.b[WIDTH-1] && diff[WIDTH-1] != bus.a[WIDTH-1];
            end
            default: alu_res = '0;
        endcase
    end
    // datapath: multiplier accumulator plus result/flag registers that hold between done pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            acc           <= '0;
            mb            <= '0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.zf        <= 1'b0;
            bus.nf        <= 1'b0;
            bus.cf        <= 1'b0;
            bus.vf        <= 1'b0;
        end else begin
            bus.done <= (accept && !is_mul) || last;
            if (accept && is_mul) begin
                acc <= {{WIDTH{1'b0}}, bus.a};
                mb  <= bus.b;
                cnt <= '0;
            end else if (state == MULT) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
            if (last) begin
                bus.result    <= acc_step[WIDTH-1:0];
                bus.result_hi <= acc_step[2*WIDTH-1:WIDTH];
                bus.zf        <= acc_step == '0;
                bus.nf        <= acc_step[2*WIDTH-1];
                bus.cf        <= |acc_step[2*WIDTH-1:WIDTH];
                bus.vf        <= |acc_step[2*WIDTH-1:WIDTH];
            end else if (accept && !is_mul) begin
                bus.result    <= alu_res;
                bus.result_hi <= '0;
                bus.zf        <= alu_res == '0;
                bus.nf        <= alu_res[WIDTH-1];
                bus.cf        <= alu_cf;
                bus.vf        <= alu_vf;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu_core.sv
// tb_seq_alu_core: WIDTH 4/8/16 cores on shared random stimulus against a behavioural model
module tb_seq_alu_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    int chk [3];
    int bad [3];
    int lit_chk = 0;
    int lit_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gw
        localparam int W = g == 0 ? 4 : g == 1 ? 8 : 16;
        seq_alu_core_if #(.WIDTH(W)) bus ();
        seq_alu_core #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
        assign bus.start = start;
        assign bus.op    = op;
        assign bus.a     = a[W-1:0];
        assign bus.b     = b[W-1:0];
        logic [3:0] fl;
        assign fl = {bus.zf, bus.nf, bus.cf, bus.vf};

        int         left;
        longint     pend;
        int         ua, ub, sa, sb, r, c, v;
        int         m = 1 << W;
        int         h = 1 << (W - 1);
        logic       e_done;
        logic [W-1:0] e_res, e_hi;
        logic [3:0] e_fl;

        // reference: a multiply is a countdown of W cycles; everything else is plain integer math
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                left = 0; e_done = 1'b0; e_res = '0; e_hi = '0; e_fl = 4'd0;
            end else if (left > 0) begin
                left--;
                e_done = left == 0;
                if (left == 0) begin
                    e_res = pend[W-1:0];
                    e_hi  = pend[2*W-1:W];
                    e_fl  = {pend == 0, pend[2*W-1], pend >= m, pend >= m};
                end
            end else if (start && op == 4'd9) begin
                left   = W;
                pend   = longint'(a[W-1:0]) * longint'(b[W-1:0]);
                e_done = 1'b0;
            end else if (start) begin
                ua = int'(a[W-1:0]);
                ub = int'(b[W-1:0]);
                sa = ua >= h ? ua - m : ua;
                sb = ub >= h ? ub - m : ub;
                c = 0;
                v = 0;
                case (op)
                    4'd0: r = ua & ub;
                    4'd1: r = ~(ua & ub) & (m - 1);
                    4'd2: r = ua | ub;
                    4'd3: r = ~(ua | ub) & (m - 1);
                    4'd4: r = ua ^ ub;
                    4'd5: r = ~(ua ^ ub) & (m - 1);
                    4'd6: r = ~ua & (m - 1);
                    4'd7: begin
                        r = (ua + ub) % m;
                        c = int'(ua + ub >= m);
                        v = int'(sa + sb >= h || sa + sb < -h);
                    end
                    4'd8: begin
                        r = (ua - ub + m) % m;
                        c = int'(ua < ub);
                        v = int'(sa - sb >= h || sa - sb < -h);
                    end
                    default: r = 0;
                endcase
                e_res  = W'(r);
                e_hi   = '0;
                e_fl   = {r == 0, r >= h, c != 0, v != 0};
                e_done = 1'b1;
            end else begin
                e_done = 1'b0;
            end
        end

        // every-cycle comparison of all outputs against the reference
        always @(negedge clk) begin
            if (!rst) begin
                chk[g]++;
                if ({bus.busy, bus.done, fl, bus.result_hi, bus.result} !== {left > 0, e_done, e_fl, e_hi, e_res}) begin
                    bad[g]++;
                    $display("FAIL cycle W=%0d t=%0t: got busy=%b done=%b zncv=%b hi=%h res=%h, expected busy=%b done=%b zncv=%b hi=%h res=%h",
                             W, $time, bus.busy, bus.done, fl, bus.result_hi, bus.result, left > 0, e_done, e_fl, e_hi, e_res);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_chk++;
        if (act !== exp) begin
            lit_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic one(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        drive(o, x, y);
        idle();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((gw[0].bus.busy || gw[1].bus.busy || gw[2].bus.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        lit("idle_timeout", 32'({gw[0].bus.busy, gw[1].bus.busy, gw[2].bus.busy}), 32'd0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 16'h0000;
            1: pick = 16'hFFFF;
            2: pick = 16'h8888;
            default: pick = 16'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        int tot;
        int fails;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lit("reset_state", 32'({gw[1].bus.busy, gw[1].bus.done, gw[1].fl, gw[1].bus.result_hi, gw[1].bus.result}), 32'd0);
        // async reset three cycles into a multiply
        drive(4'd9, 16'h0003, 16'h0005);
        idle();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        lit("async_rst_w8", 32'({gw[1].bus.busy, gw[1].bus.done, gw[1].fl, gw[1].bus.result_hi, gw[1].bus.result}), 32'd0);
        lit("async_rst_w16", {gw[2].bus.busy, gw[2].bus.done, gw[2].fl, 10'd0}, 32'd0);
        @(negedge clk);
        lit("rst_busy", 32'(gw[1].bus.busy), 32'd0);
        rst = 1'b0;
        one(4'd7, 16'h0001, 16'h0001);
        lit("add_1_1", 32'(gw[1].bus.result), 32'h02);
        lit("add_1_1_done", 32'(gw[1].bus.done), 32'd1);
        one(4'd7, 16'h007F, 16'h0001);
        lit("add_7f_1", 32'({gw[1].fl, gw[1].bus.result}), 32'h580);
        one(4'd7, 16'h00FF, 16'h0001);
        lit("add_ff_1", 32'({gw[1].fl, gw[1].bus.result}), 32'hA00);
        one(4'd8, 16'h0005, 16'h0005);
        lit("sub_5_5", 32'({gw[1].fl, gw[1].bus.result}), 32'h800);
        one(4'd8, 16'h0000, 16'h0001);
        lit("sub_0_1", 32'({gw[1].fl, gw[1].bus.result}), 32'h6FF);
        one(4'd8, 16'h0080, 16'h0001);
        lit("sub_80_1", 32'({gw[1].fl, gw[1].bus.result}), 32'h17F);
        // multiply timing and full-width product
        drive(4'd9, 16'hFFFF, 16'hFFFF);
        idle();
        n = 0;
        while (gw[1].bus.busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        lit("mul_busy_cycles", 32'(n), 32'd8);
        lit("mul_done", 32'(gw[1].bus.done), 32'd1);
        lit("mul_ff_ff", 32'({gw[1].fl, gw[1].bus.result_hi, gw[1].bus.result}), 32'h7FE01);
        wait_idle();
        lit("mul_w4", 32'({gw[0].bus.result_hi, gw[0].bus.result}), 32'hE1);
        lit("mul_w16", {gw[2].bus.result_hi, gw[2].bus.result}, 32'hFFFE0001);
        lit("mul_w16_flags", 32'(gw[2].fl), 32'h7);
        one(4'd9, 16'h0003, 16'h0000);
        wait_idle();
        lit("mul_3_0", 32'({gw[1].fl, gw[1].bus.result_hi, gw[1].bus.result}), 32'h80000);
        // start while busy is ignored
        drive(4'd9, 16'h0003, 16'h0005);
        drive(4'd7, 16'h0010, 16'h0010);
        drive(4'd7, 16'h0010, 16'h0010);
        idle();
        wait_idle();
        lit("mul_ignore_start", 32'({gw[1].fl, gw[1].bus.result_hi, gw[1].bus.result}), 32'h0000F);
        // back-to-back single-cycle ops
        drive(4'd4, 16'h00F0, 16'h00FF);
        drive(4'd0, 16'h00F0, 16'h003C);
        lit("b2b_xor", 32'({gw[1].bus.done, gw[1].bus.result}), 32'h10F);
        drive(4'd2, 16'h000F, 16'h0030);
        lit("b2b_and", 32'({gw[1].bus.done, gw[1].bus.result}), 32'h130);
        idle();
        lit("b2b_or", 32'({gw[1].bus.done, gw[1].bus.result}), 32'h13F);
        @(negedge clk);
        lit("done_drop", 32'({gw[1].bus.done, gw[1].bus.result}), 32'h03F);
        // logic and reserved ops
        one(4'd3, 16'h0000, 16'h0000);
        lit("nor_0_0", 32'({gw[1].fl, gw[1].bus.result}), 32'h4FF);
        one(4'd5, 16'h00A5, 16'h00A5);
        lit("xnor_a5", 32'(gw[1].bus.result), 32'hFF);
        one(4'd6, 16'h00FF, 16'h0000);
        lit("not_ff", 32'({gw[1].fl, gw[1].bus.result}), 32'h800);
        one(4'd15, 16'h0012, 16'h0034);
        lit("reserved_15", 32'({gw[1].bus.done, gw[1].fl, gw[1].bus.result_hi, gw[1].bus.result}), 32'h18_0000);
        // randomized traffic
        repeat (800) begin
            @(negedge clk);
            start = $urandom_range(0, 9) < 6;
            op = $urandom_range(0, 4) == 0 ? 4'd9 : 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
        end
        idle();
        wait_idle();
        @(negedge clk);
        tot = lit_chk + chk[0] + chk[1] + chk[2];
        fails = lit_bad + bad[0] + bad[1] + bad[2];
        $display("%0d/%0d checks passed", tot - fails, tot);
        $finish;
    end
endmodule
